// File: rtl/i2c_write_ctrl.sv
// I2C master write sequencer: START, 7-bit address + W, N data bytes with ACK checks, STOP.
// Drives open-drain tri-state controls for SCL/SDA; data bytes arrive over valid/ready.
module i2c_write_ctrl #(
  parameter int CLK_DIV = 125
) (
  input  logic       I_CLK,
  input  logic       I_RESET,
  input  logic       I_START,
  input  logic [6:0] I_ADDR,
  input  logic [7:0] I_DATA,
  input  logic       I_DATA_VALID,
  input  logic       I_DATA_LAST,
  output logic       O_DATA_READY,
  input  logic       I_SCL,
  input  logic       I_SDA,
  output logic       O_SCL_T,
  output logic       O_SDA_T,
  output logic       O_BUSY,
  output logic       O_DONE,
  output logic       O_NACK
);
  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    IDLE, START, ADDR_BIT, ADDR_ACK, LOAD, DATA_BIT, DATA_ACK, STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    phase;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          last;

  logic slot, stretch, tick;

  // Slave clock stretching: P2 releases SCL, but the timer waits until the pad is really high.
  assign slot    = (state == ADDR_BIT) || (state == DATA_BIT) ||
                   (state == ADDR_ACK) || (state == DATA_ACK);
  assign stretch = slot && (phase == 2'd2) && !I_SCL;
  assign tick    = (cnt == CW'(CLK_DIV - 1)) && !stretch;

  assign O_DATA_READY = (state == LOAD);

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      phase   <= 2'd0;
      shift   <= 8'h00;
      bit_cnt <= 3'd0;
      last    <= 1'b0;
      O_SCL_T <= 1'b1;
      O_SDA_T <= 1'b1;
      O_BUSY  <= 1'b0;
      O_DONE  <= 1'b0;
      O_NACK  <= 1'b0;
    end else begin
      O_DONE <= 1'b0;
      if (state != IDLE && state != LOAD && !stretch)
        cnt <= tick ? '0 : cnt + 1'b1;

      case (state)
        IDLE: begin
          O_SCL_T <= 1'b1;
          O_SDA_T <= 1'b1;
          cnt     <= '0;
          phase   <= 2'd0;
          if (I_START) begin
            shift   <= {I_ADDR, 1'b0};
            bit_cnt <= 3'd7;
            O_NACK  <= 1'b0;
            O_BUSY  <= 1'b1;
            state   <= START;
          end
        end

        START: if (tick) begin
          case (phase)
            2'd0: begin O_SDA_T <= 1'b0; phase <= 2'd1; end
            2'd1: begin O_SCL_T <= 1'b0; phase <= 2'd2; end
            default: begin
              O_SDA_T <= shift[7];
              phase   <= 2'd0;
              state   <= ADDR_BIT;
            end
          endcase
        end

        ADDR_BIT, DATA_BIT: if (tick) begin
          phase <= phase + 2'd1;
          case (phase)
            2'd1: O_SCL_T <= 1'b1;
            2'd3: begin
              O_SCL_T <= 1'b0;
              shift   <= {shift[6:0], 1'b0};
              if (bit_cnt == 3'd0) begin
                O_SDA_T <= 1'b1;
                state   <= (state == ADDR_BIT) ? ADDR_ACK : DATA_ACK;
              end else begin
                O_SDA_T <= shift[6];
                bit_cnt <= bit_cnt - 1'b1;
              end
            end
            default: ;
          endcase
        end

        ADDR_ACK, DATA_ACK: if (tick) begin
          phase <= phase + 2'd1;
          case (phase)
            2'd1: O_SCL_T <= 1'b1;
            2'd3: begin
              O_SCL_T <= 1'b0;
              if (I_SDA) begin
                O_NACK  <= 1'b1;
                O_SDA_T <= 1'b0;
                state   <= STOP;
              end else if (state == ADDR_ACK || !last) begin
                state <= LOAD;
              end else begin
                O_SDA_T <= 1'b0;
                state   <= STOP;
              end
            end
            default: ;
          endcase
        end

        // SCL stays low here for as long as the core takes to supply a byte.
        LOAD: if (I_DATA_VALID) begin
          shift   <= I_DATA;
          last    <= I_DATA_LAST;
          bit_cnt <= 3'd7;
          O_SDA_T <= I_DATA[7];
          phase   <= 2'd0;
          cnt     <= '0;
          state   <= DATA_BIT;
        end

        STOP: if (tick) begin
          case (phase)
            2'd0: begin O_SCL_T <= 1'b1; phase <= 2'd1; end
            2'd1: begin O_SDA_T <= 1'b1; phase <= 2'd2; end
            default: begin
              O_DONE <= 1'b1;
              O_BUSY <= 1'b0;
              phase  <= 2'd0;
              state  <= IDLE;
            end
          endcase
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_write_ctrl.sv
// Bench for i2c_write_ctrl: open-drain pad model, bus-level slave monitor, byte scoreboard.
module tb_i2c_write_ctrl;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] addr = 7'h00;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       dlast = 1'b0;
  logic       ready, scl_t, sda_t, busy, done, nack;
  logic       scl_hold = 1'b0;
  logic       sda_ack = 1'b0;
  logic       ack_en = 1'b0;
  logic       scl, sda;

  assign scl = scl_t & ~scl_hold;
  assign sda = sda_t & ~sda_ack;

  always #5 clk = ~clk;

  i2c_write_ctrl #(.CLK_DIV(D)) dut (
    .I_CLK(clk), .I_RESET(rst), .I_START(start), .I_ADDR(addr), .I_DATA(data),
    .I_DATA_VALID(valid), .I_DATA_LAST(dlast), .O_DATA_READY(ready),
    .I_SCL(scl), .I_SDA(sda), .O_SCL_T(scl_t), .O_SDA_T(sda_t),
    .O_BUSY(busy), .O_DONE(done), .O_NACK(nack)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Slave/bus monitor: decodes START/STOP, bytes and ACK slots from the pad levels.
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  int         bitn = 0, n_start = 0, n_stop = 0;
  logic [7:0] sh = 8'h00;
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];
  bit         ack_rel[$];

  always @(negedge clk) begin
    prev_scl <= scl;
    prev_sda <= sda;
    if (rst) begin
      bitn    <= 0;
      sda_ack <= 1'b0;
    end else if (prev_scl && scl && prev_sda && !sda) begin
      n_start <= n_start + 1;
      bitn    <= 0;
    end else if (prev_scl && scl && !prev_sda && sda) begin
      n_stop <= n_stop + 1;
    end else if (!prev_scl && scl) begin
      if (bitn == 8) begin
        ack_rel.push_back(sda_t);
        bitn <= 0;
      end else begin
        sh <= {sh[6:0], sda};
        if (bitn == 7) obs_q.push_back({sh[6:0], sda});
        bitn <= bitn + 1;
      end
    end else if (prev_scl && !scl) begin
      if (bitn == 8 && ack_en) sda_ack <= 1'b1;
      else if (bitn == 0) sda_ack <= 1'b0;
    end
  end

  typedef struct {
    logic [6:0]      addr;
    int              n;
    logic [2:0][7:0] d;
    logic            ack;
    int              wait1;   // idle cycles in LOAD before byte index 1
    int              poke;    // 1: I_START once NACK seen, 2: I_START at first LOAD
    logic            stretch;
    logic            exp_nack;
    logic            exp_ready;
  } vec_t;

  vec_t tbl[4];

  task automatic run_txn(input vec_t v, input string tag);
    int b = 0, waitc = 0, done_cnt = 0, post = 0, scl_err = 0, st = 0, hc = 0, hi = 0;
    int s0, p0, bad_rel;
    bit ready_seen = 0, poked = 0;
    ack_en = v.ack;
    exp_q.push_back({v.addr, 1'b0});
    if (v.ack) for (int i = 0; i < v.n; i++) exp_q.push_back(v.d[i]);
    s0 = n_start;
    p0 = n_stop;
    @(negedge clk);
    addr  = v.addr;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_set"}, busy, 1);
    for (int cyc = 0; cyc < 20000 && post < 10; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      valid = 1'b0;
      if (ready) begin
        if (v.poke == 2 && !poked) begin start = 1'b1; addr = 7'h7F; poked = 1; end
        ready_seen = 1;
        if (b < v.n) begin
          if (b == 1 && waitc < v.wait1) begin
            waitc++;
            if (scl_t !== 1'b0) scl_err++;
          end else begin
            valid = 1'b1;
            data  = v.d[b];
            dlast = (b == v.n - 1);
            b++;
          end
        end
      end
      if (v.poke == 1 && !poked && nack && busy) begin start = 1'b1; addr = 7'h7F; poked = 1; end
      if (v.stretch) begin
        case (st)
          0: if (obs_q.size() == 0 && bitn == 3 && scl_t == 1'b0) begin scl_hold = 1'b1; st = 1; end
          1: if (scl_t) begin
               hc++;
               if (hc == 30) begin scl_hold = 1'b0; hi = 1; st = 2; end
             end
          2: if (scl) hi++; else st = 3;
          default: ;
        endcase
      end
      if (done) done_cnt++;
      if (done_cnt > 0) post++;
    end
    start = 1'b0;
    valid = 1'b0;
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_nack"}, nack, v.exp_nack);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_ready_seen"}, ready_seen, v.exp_ready);
    chk({tag, "_starts"}, n_start - s0, 1);
    chk({tag, "_stops"}, n_stop - p0, 1);
    if (v.wait1 > 0) chk({tag, "_scl_low_wait"}, scl_err, 0);
    if (v.stretch) begin
      chk({tag, "_stretch_done"}, st, 3);
      chk({tag, "_high_time"}, hi, 2 * D);
    end
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      if (obs_q.size() == 0) chk({tag, "_byte_missing"}, 32'hFFFF, e);
      else chk({tag, "_byte"}, obs_q.pop_front(), e);
    end
    chk({tag, "_extra_bytes"}, obs_q.size(), 0);
    bad_rel = 0;
    foreach (ack_rel[i]) if (!ack_rel[i]) bad_rel++;
    chk({tag, "_ack_released"}, bad_rel, 0);
    ack_rel.delete();
    obs_q.delete();
  endtask

  initial begin
    bit got;
    int dn;
    vec_t v;
    tbl[0] = '{addr:7'h50, n:1, d:{8'h00, 8'h00, 8'hA5}, ack:1, wait1:0, poke:0,
               stretch:0, exp_nack:0, exp_ready:1};
    tbl[1] = '{addr:7'h23, n:1, d:{8'h00, 8'h00, 8'h5C}, ack:0, wait1:0, poke:1,
               stretch:0, exp_nack:1, exp_ready:0};
    tbl[2] = '{addr:7'h3A, n:3, d:{8'h33, 8'h22, 8'h11}, ack:1, wait1:20, poke:2,
               stretch:0, exp_nack:0, exp_ready:1};
    tbl[3] = '{addr:7'h68, n:2, d:{8'h00, 8'hC3, 8'h5A}, ack:1, wait1:0, poke:0,
               stretch:1, exp_nack:0, exp_ready:1};

    repeat (3) @(negedge clk);
    chk("rst_scl_t", scl_t, 1);
    chk("rst_sda_t", sda_t, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_nack", nack, 0);
    chk("rst_ready", ready, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of a data byte.
    ack_en = 1'b1;
    addr   = 7'h50;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 0;
    for (int c = 0; c < 2000 && !got; c++) begin
      @(negedge clk);
      if (ready) begin valid = 1'b1; data = 8'hC3; dlast = 1'b1; got = 1; end
    end
    @(negedge clk);
    valid = 1'b0;
    chk("mid_ready", got, 1);
    got = 0;
    for (int c = 0; c < 2000 && !got; c++) begin
      @(negedge clk);
      if (bitn == 4) got = 1;
    end
    chk("mid_reach_bit4", got, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_scl_t", scl_t, 1);
    chk("mid_sda_t", sda_t, 1);
    chk("mid_busy", busy, 0);
    chk("mid_nack", nack, 0);
    chk("mid_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("mid_no_done", dn, 0);
    exp_q.delete();
    obs_q.delete();
    ack_rel.delete();

    v = '{addr:7'h2C, n:1, d:{8'h00, 8'h00, 8'h96}, ack:1, wait1:0, poke:0,
          stretch:0, exp_nack:0, exp_ready:1};
    run_txn(v, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_write_ctrl.md
Name: i2c_write_ctrl

Overview:
- I2C master write sequencer for the FSSPrototype peripheral bus.
- Drives the tri-state controls of two open-drain pads, SCL and SDA.
- Generates START, the 7-bit address plus W bit, N data bytes with ACK checks, then STOP.
- Data bytes come from the core over a valid/ready handshake. The block reports completion and NACK.

Parameters:
- CLK_DIV, 125, system clocks per SCL quarter-period phase (125 gives 100 kHz SCL at 50 MHz); legal range is CLK_DIV >= 2.

Ports:
- I_CLK  input  1  system clock
- I_RESET  input  1  synchronous, active-high reset
- I_START  input  1  1-cycle request; accepted only when O_BUSY=0
- I_ADDR  input  7  slave address, captured on accepted I_START
- I_DATA  input  8  write byte
- I_DATA_VALID  input  1  I_DATA is valid
- I_DATA_LAST  input  1  qualifies I_DATA as final byte of the transaction
- O_DATA_READY  output  1  block accepts I_DATA this cycle
- I_SCL  input  1  sampled SCL pad level (for clock stretching)
- I_SDA  input  1  sampled SDA pad level (for ACK)
- O_SCL_T  output  1  SCL tri-state control: 1 = release (Z), 0 = drive low
- O_SDA_T  output  1  SDA tri-state control: 1 = release (Z), 0 = drive low
- O_BUSY  output  1  high from the cycle after START acceptance until O_DONE
- O_DONE  output  1  1-cycle pulse when STOP completes
- O_NACK  output  1  sticky; set on any NACK, cleared on the next accepted I_START

Behaviour:
- Reset values: O_SCL_T=1, O_SDA_T=1, O_BUSY=0, O_DONE=0, O_NACK=0, O_DATA_READY=0; FSM in IDLE; phase counter 0.
- Reset mid-transaction: both lines are released on the next clock. No STOP is generated.
- Phase timer: counts 0..CLK_DIV-1. A phase ends when the count reaches CLK_DIV-1.
- FSM states: IDLE, START, ADDR_BIT, ADDR_ACK, LOAD, DATA_BIT, DATA_ACK, STOP.
- IDLE:
  - Both lines released.
  - I_START accepted: shift reg <= {I_ADDR,1'b0}, bit count <= 7, O_NACK <= 0, O_BUSY <= 1, go to START.
- START, 3 phases:
  - P0: SCL=1, SDA=1.
  - P1: SCL=1, SDA=0.
  - P2: SCL=0, SDA=0.
  - Then go to ADDR_BIT.
- Bit slot, 4 phases (ADDR_BIT and DATA_BIT):
  - P0: SCL=0, SDA_T = shift[7].
  - P1: SCL=0.
  - P2: SCL released; the timer holds while I_SCL=0 (clock stretching).
  - P3: SCL=1.
  - End of P3: shift left; bit count decrements. After bit 0, go to the matching ACK state.
- ACK slot: same 4 phases with SDA released.
  - I_SDA is sampled on the last cycle of P3.
  - I_SDA=1 (NACK): O_NACK <= 1, go to STOP.
- After ADDR_ACK (ACK): go to LOAD.
- LOAD:
  - SCL held low, SDA held at its previous value.
  - O_DATA_READY=1.
  - Transfer on I_DATA_VALID && O_DATA_READY: shift <= I_DATA, last flag <= I_DATA_LAST, bit count <= 7, go to DATA_BIT.
  - Waits indefinitely with SCL low; this is legal I2C.
- After DATA_ACK (ACK): go to STOP if last flag is set, else go to LOAD.
- STOP, 3 phases:
  - P0: SCL=0, SDA=0.
  - P1: SCL=1, SDA=0.
  - P2: SCL=1, SDA=1.
  - Then O_DONE=1 for one cycle, O_BUSY <= 0, go to IDLE.
- O_DATA_READY is combinational from state (high only in LOAD).
- I_START while O_BUSY=1 is ignored and does not affect O_NACK.
- Timing: with zero LOAD wait and no stretching, the minimum START-to-DONE time is (3 + 9·4·(1+N) + 3)·CLK_DIV + N + 2 cycles.
- SDA changes only while SCL is low, except for the START/STOP edges.

Test Plan:
- Single-byte write, CLK_DIV=4: addr 0x50, data 0xA5 with LAST, slave model ACKs.
  - Required: SDA sequence START, 0xA0, ACK, 0xA5, ACK, STOP.
  - Required: O_DONE exactly once; O_NACK=0; O_BUSY low after DONE.
- Address NACK: addr 0x23, no slave drives ACK.
  - Required: O_NACK=1 after ADDR_ACK; STOP follows immediately; O_DATA_READY never asserted; O_DONE pulses.
- Three-byte burst with I_DATA_VALID delayed 20 cycles before byte 2.
  - Required: SCL held low (O_SCL_T=0) for the whole wait.
  - Required: bytes 0x11, 0x22, 0x33 appear in order; O_DONE pulses after the third ACK.
- Clock stretching: slave holds I_SCL=0 for 30 cycles during P2 of bit 3.
  - Required: the phase timer freezes and the bit's high time is still CLK_DIV·2 after release.
- Reset mid-byte (during DATA_BIT bit 4):
  - Required: next cycle O_SCL_T=1, O_SDA_T=1, O_BUSY=0, O_NACK=0, no O_DONE.
  - Required: a new I_START then completes normally.
- I_START pulsed while busy:
  - Required: ignored; the transaction finishes unchanged; O_NACK is unchanged.
